// File: rtl/dc_winner_reporter.sv
// dc_winner_reporter: validates comparator greatest-flags against operands and
// serialises each flagged winner as an index/value record on a valid/ready stream.
module dc_winner_reporter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic [3:0]       gt_flags_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [1:0]       out_idx_o,
   output logic [WIDTH-1:0] out_val_o,
   output logic             out_last_o,
   output logic             out_err_o,
   output logic [2:0]       out_cnt_o
);
   typedef enum logic {IDLE, EMIT} state_t;
   state_t                  state_q, state_d;
   logic [3:0][WIDTH-1:0]   ops_q, ops_d, in_ops;
   logic [3:0]              mask_q, mask_d;
   logic                    err_q, err_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [WIDTH-1:0]        mx;
   logic                    bad;
   logic [2:0]              cnt_c;
   logic [1:0]              idx;
   logic                    last;
   logic                    emit;
   assign in_ops = {d_i, c_i, b_i, a_i};
   // Flags are consistent exactly when the flagged set equals the set of maximal operands.
   always_comb begin
      mx = '0;
      for (int i = 0; i < 4; i++) mx = (in_ops[i] > mx) ? in_ops[i] : mx;
      bad   = (gt_flags_i == 4'd0);
      cnt_c = 3'd0;
      for (int i = 0; i < 4; i++) begin
         bad   = bad | (gt_flags_i[i] != (in_ops[i] == mx));
         cnt_c = cnt_c + {2'b00, gt_flags_i[i]};
      end
   end
   assign idx  = mask_q[0] ? 2'd0 : mask_q[1] ? 2'd1 : mask_q[2] ? 2'd2 : mask_q[3] ? 2'd3 : 2'd0;
   assign last = $onehot0(mask_q);
   assign emit = (state_q == EMIT);
   always_comb begin
      state_d = state_q;
      ops_d   = ops_q;
      mask_d  = mask_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (!emit && in_valid_i) begin
         state_d = EMIT;
         ops_d   = in_ops;
         mask_d  = gt_flags_i;
         err_d   = bad;
         cnt_d   = cnt_c;
      end else if (emit && out_ready_i) begin
         mask_d  = mask_q & (mask_q - 4'd1);
         state_d = last ? IDLE : EMIT;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ops_q   <= '0;
         mask_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         ops_q   <= ops_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
   // Outputs are forced to zero outside EMIT so idle and reset look identical downstream.
   assign in_ready_o  = !emit && !rst;
   assign out_valid_o = emit;
   assign out_idx_o   = emit ? idx : 2'd0;
   assign out_val_o   = emit ? ops_q[idx] : '0;
   assign out_last_o  = emit && last;
   assign out_err_o   = emit && err_q;
   assign out_cnt_o   = emit ? cnt_q : 3'd0;
endmodule

// File: tb/tb_dc_winner_reporter.sv
// tb_dc_winner_reporter: directed vectors with a record-queue reference model checked every cycle.
module tb_dc_winner_reporter;
   logic       clk = 0, rst = 1;
   logic       in_valid = 0, in_ready, out_valid, out_ready = 1, out_last, out_err;
   logic [3:0] a = 0, b = 0, c = 0, d = 0, flags = 0, out_val;
   logic [1:0] out_idx;
   logic [2:0] out_cnt;
   int checks = 0, failures = 0;
   typedef struct {int idx; int val; int last; int err; int cnt;} rec_t;
   rec_t q[$];

   dc_winner_reporter #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .b_i(b), .c_i(c), .d_i(d), .gt_flags_i(flags),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_idx_o(out_idx),
      .out_val_o(out_val), .out_last_o(out_last), .out_err_o(out_err), .out_cnt_o(out_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
      end
   endtask

   // Expected records for one accepted transaction, straight from the flag rules.
   task automatic push_txn(input int v0, v1, v2, v3, input logic [3:0] f);
      int v[4];
      int e, n, hi;
      rec_t r;
      v = '{v0, v1, v2, v3};
      e = (f == 0) ? 1 : 0;
      n = 0;
      hi = 0;
      for (int i = 0; i < 4; i++) if (f[i]) begin
         n++;
         hi = i;
         for (int j = 0; j < 4; j++) begin
            if (f[j] && v[j] != v[i]) e = 1;
            if (!f[j] && v[j] >= v[i]) e = 1;
            if (v[j] > v[i]) e = 1;
         end
      end
      if (f == 0) begin
         r = '{0, v[0], 1, 1, 0};
         q.push_back(r);
      end else
         for (int i = 0; i < 4; i++) if (f[i]) begin
            r = '{i, v[i], (i == hi) ? 1 : 0, e, n};
            q.push_back(r);
         end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) q.delete();
      else if (q.size() > 0) begin
         if (out_ready) void'(q.pop_front());
      end else if (in_valid) push_txn(a, b, c, d, flags);
   end

   always @(negedge clk) begin
      chk("valid", out_valid, (q.size() > 0 && !rst) ? 1 : 0);
      chk("ready", in_ready, (q.size() == 0 && !rst) ? 1 : 0);
      if (q.size() > 0 && !rst) begin
         chk("idx", out_idx, q[0].idx);
         chk("val", out_val, q[0].val);
         chk("last", out_last, q[0].last);
         chk("err", out_err, q[0].err);
         chk("cnt", out_cnt, q[0].cnt);
      end
      if (rst) chk("rst_zero", int'({out_idx, out_val, out_last, out_err, out_cnt}), 0);
   end

   task automatic send(input logic [3:0] na, nb, nc, nd, nf);
      int k;
      @(posedge clk); #1;
      for (k = 0; k < 50 && !in_ready; k++) begin @(posedge clk); #1; end
      chk("accept_timeout", in_ready, 1);
      {a, b, c, d, flags} = {na, nb, nc, nd, nf};
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic rec(input string n, input int i, v, l, e, cn);
      @(negedge clk);
      chk({n, "_valid"}, out_valid, 1);
      chk({n, "_idx"}, out_idx, i);
      chk({n, "_val"}, out_val, v);
      chk({n, "_last"}, out_last, l);
      chk({n, "_err"}, out_err, e);
      chk({n, "_cnt"}, out_cnt, cn);
      chk({n, "_inrdy"}, in_ready, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst = 0;
      @(negedge clk);
      chk("post_reset_ready", in_ready, 1);
      send(9, 3, 5, 1, 4'b0001);
      rec("t1", 0, 9, 1, 0, 1);
      @(negedge clk);
      chk("t1_ready_back", in_ready, 1);
      send(7, 7, 2, 7, 4'b1011);
      rec("t2a", 0, 7, 0, 0, 3);
      rec("t2b", 1, 7, 0, 0, 3);
      rec("t2c", 3, 7, 1, 0, 3);
      @(posedge clk); #1 out_ready = 0;
      send(7, 7, 2, 7, 4'b1011);
      repeat (3) rec("t3hold", 0, 7, 0, 0, 3);
      @(posedge clk); #1 out_ready = 1;
      rec("t3a", 0, 7, 0, 0, 3);
      rec("t3b", 1, 7, 0, 0, 3);
      rec("t3c", 3, 7, 1, 0, 3);
      send(4, 8, 1, 0, 4'b0001);
      rec("t4wrong", 0, 4, 1, 1, 1);
      send(5, 5, 0, 0, 4'b0001);
      rec("t4tie", 0, 5, 1, 1, 1);
      send(6, 1, 2, 3, 4'b0000);
      rec("t5zero", 0, 6, 1, 1, 0);
      send(15, 15, 15, 15, 4'b1111);
      rec("t6a", 0, 15, 0, 0, 4);
      @(posedge clk); #2 rst = 1;
      #1 chk("t6_abort_valid", out_valid, 0);
      @(negedge clk);
      chk("t6_rst_ready", in_ready, 0);
      @(posedge clk); #2 rst = 0;
      @(negedge clk);
      chk("t6_release_ready", in_ready, 1);
      repeat (4) begin @(negedge clk); chk("t6_no_stale", out_valid, 0); end
      send(3, 9, 9, 2, 4'b0110);
      rec("t7a", 1, 9, 0, 0, 2);
      rec("t7b", 2, 9, 1, 0, 2);
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
